// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: frames UART receiver byte strobes into host command packets
// (SYNC, OPCODE, LEN, payload, XOR checksum). It emits a command header pulse,
// a little-endian 32-bit payload word stream with valid/ready handshake, and
// reports packet completion or abort with an error code.
module uart_cmd_parser #(
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
   parameter int unsigned TIMEOUT_CLKS = 100_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        cmd_start,
   output logic [7:0]  cmd_opcode,
   output logic [7:0]  cmd_len,
   output logic [31:0] word_data,
   output logic        word_valid,
   input  logic        word_ready,
   output logic        word_last,
   output logic        pkt_done,
   output logic        pkt_err,
   output logic [1:0]  err_code,
   output logic        busy
);

   localparam int unsigned TMO_W = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);

   localparam logic [1:0] ERR_CSUM = 2'd1;
   localparam logic [1:0] ERR_TMO  = 2'd2;
   localparam logic [1:0] ERR_OVR  = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_OPCODE,
      S_LEN,
      S_PAYLOAD,
      S_CHECK
   } state_e;

   state_e            state_q;
   logic [7:0]        opcode_q;
   logic [7:0]        csum_q;
   logic [7:0]        pay_cnt_q;
   logic [31:0]       acc_q;
   logic [TMO_W-1:0]  tmo_q;

   logic              cmd_start_q;
   logic [7:0]        cmd_opcode_q;
   logic [7:0]        cmd_len_q;
   logic [31:0]       word_data_q;
   logic              word_valid_q;
   logic              word_last_q;
   logic              pkt_done_q;
   logic              pkt_err_q;
   logic [1:0]        err_code_q;
   logic              busy_q;

   logic [31:0]       acc_d;
   logic              last_byte;
   logic              load;
   logic              overrun;
   logic              csum_bad;
   logic              tmo_hit;
   logic              err_hit;
   logic [1:0]        err_sel;

   // Lane merge of the incoming payload byte, word-load and abort conditions
   always_comb begin
      acc_d = acc_q;
      case (pay_cnt_q[1:0])
         2'd0:    acc_d[7:0]   = rx_data;
         2'd1:    acc_d[15:8]  = rx_data;
         2'd2:    acc_d[23:16] = rx_data;
         default: acc_d[31:24] = rx_data;
      endcase
      last_byte = (8'(pay_cnt_q + 8'd1) == cmd_len_q);
      load      = rx_valid && (state_q == S_PAYLOAD) &&
                  ((pay_cnt_q[1:0] == 2'd3) || last_byte);
      overrun   = load && word_valid_q && !word_ready;
      csum_bad  = rx_valid && (state_q == S_CHECK) && (rx_data != csum_q);
      tmo_hit   = (state_q != S_IDLE) && !rx_valid && (tmo_q == TMO_LAST);
      err_hit   = overrun || csum_bad || tmo_hit;
      if (csum_bad) begin
         err_sel = ERR_CSUM;
      end else if (tmo_hit) begin
         err_sel = ERR_TMO;
      end else begin
         err_sel = ERR_OVR;
      end
   end

   // Packet FSM with registered pulses, word stream and error reporting
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         opcode_q     <= '0;
         csum_q       <= '0;
         pay_cnt_q    <= '0;
         acc_q        <= '0;
         tmo_q        <= '0;
         cmd_start_q  <= 1'b0;
         cmd_opcode_q <= '0;
         cmd_len_q    <= '0;
         word_data_q  <= '0;
         word_valid_q <= 1'b0;
         word_last_q  <= 1'b0;
         pkt_done_q   <= 1'b0;
         pkt_err_q    <= 1'b0;
         err_code_q   <= '0;
         busy_q       <= 1'b0;
      end else begin
         cmd_start_q <= 1'b0;
         pkt_done_q  <= 1'b0;
         pkt_err_q   <= 1'b0;

         if (word_valid_q && word_ready) begin
            word_valid_q <= 1'b0;
            word_last_q  <= 1'b0;
         end

         if ((state_q == S_IDLE) || rx_valid) begin
            tmo_q <= '0;
         end else begin
            tmo_q <= tmo_q + TMO_W'(1);
         end

         if (rx_valid) begin
            case (state_q)
               S_IDLE: begin
                  if (rx_data == SYNC_BYTE) begin
                     state_q <= S_OPCODE;
                     busy_q  <= 1'b1;
                  end
               end
               S_OPCODE: begin
                  opcode_q <= rx_data;
                  csum_q   <= rx_data;
                  state_q  <= S_LEN;
               end
               S_LEN: begin
                  cmd_opcode_q <= opcode_q;
                  cmd_len_q    <= rx_data;
                  cmd_start_q  <= 1'b1;
                  csum_q       <= csum_q ^ rx_data;
                  pay_cnt_q    <= '0;
                  acc_q        <= '0;
                  state_q      <= (rx_data == 8'd0) ? S_CHECK : S_PAYLOAD;
               end
               S_PAYLOAD: begin
                  csum_q    <= csum_q ^ rx_data;
                  pay_cnt_q <= pay_cnt_q + 8'd1;
                  if (load) begin
                     word_data_q  <= acc_d;
                     word_valid_q <= 1'b1;
                     word_last_q  <= last_byte;
                     acc_q        <= '0;
                  end else begin
                     acc_q <= acc_d;
                  end
                  if (last_byte) begin
                     state_q <= S_CHECK;
                  end
               end
               S_CHECK: begin
                  if (!csum_bad) begin
                     pkt_done_q <= 1'b1;
                  end
                  csum_q  <= '0;
                  acc_q   <= '0;
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
               default: begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end

         // Abort overrides whatever the byte handling above scheduled
         if (err_hit) begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            pkt_err_q    <= 1'b1;
            err_code_q   <= err_sel;
            word_valid_q <= 1'b0;
            word_last_q  <= 1'b0;
            acc_q        <= '0;
            csum_q       <= '0;
            pay_cnt_q    <= '0;
         end
      end
   end

   assign cmd_start  = cmd_start_q;
   assign cmd_opcode = cmd_opcode_q;
   assign cmd_len    = cmd_len_q;
   assign word_data  = word_data_q;
   assign word_valid = word_valid_q;
   assign word_last  = word_last_q;
   assign pkt_done   = pkt_done_q;
   assign pkt_err    = pkt_err_q;
   assign err_code   = err_code_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: table of directed packets, hand-written corner sequences
// (timeout, overrun, reset mid-packet) and randomized packets checked against
// a packet-level reference model via an event scoreboard.
module tb_uart_cmd_parser;

   localparam int unsigned T = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        word_ready = 1'b1;
   logic        cmd_start;
   logic [7:0]  cmd_opcode;
   logic [7:0]  cmd_len;
   logic [31:0] word_data;
   logic        word_valid;
   logic        word_last;
   logic        pkt_done;
   logic        pkt_err;
   logic [1:0]  err_code;
   logic        busy;

   uart_cmd_parser #(
      .SYNC_BYTE    (8'hA5),
      .TIMEOUT_CLKS (T)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .cmd_start  (cmd_start),
      .cmd_opcode (cmd_opcode),
      .cmd_len    (cmd_len),
      .word_data  (word_data),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .word_last  (word_last),
      .pkt_done   (pkt_done),
      .pkt_err    (pkt_err),
      .err_code   (err_code),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]  kind;
      logic [31:0] d;
      logic        last;
   } ev_t;

   localparam logic [1:0] EV_START = 2'd0;
   localparam logic [1:0] EV_WORD  = 2'd1;
   localparam logic [1:0] EV_DONE  = 2'd2;
   localparam logic [1:0] EV_ERR   = 2'd3;

   ev_t obs_q[$];
   ev_t exp_q[$];
   int  n_vec  = 0;
   int  n_miss = 0;
   logic [1:0] exp_code = 2'd0;

   // Directed packet: bytes right-aligned in b (first byte most significant)
   typedef struct {
      logic [95:0] b;
      int          n;
      logic [7:0]  op;
      logic [7:0]  len;
      int          nw;
      logic [31:0] w0;
      logic [31:0] w1;
      int          code;
   } vec_t;

   localparam int NV = 7;
   vec_t tbl[NV];

   // Observed events, sampled on the falling edge
   always @(negedge clk) begin
      ev_t e;
      if (rst_n) begin
         if (cmd_start) begin
            e.kind = EV_START; e.d = {16'h0, cmd_opcode, cmd_len}; e.last = 1'b0;
            obs_q.push_back(e);
         end
         if (word_valid && word_ready) begin
            e.kind = EV_WORD; e.d = word_data; e.last = word_last;
            obs_q.push_back(e);
         end
         if (pkt_done) begin
            e.kind = EV_DONE; e.d = 32'h0; e.last = 1'b0;
            obs_q.push_back(e);
         end
         if (pkt_err) begin
            e.kind = EV_ERR; e.d = {30'h0, err_code}; e.last = 1'b0;
            obs_q.push_back(e);
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One-cycle byte strobe followed by gap idle cycles
   task automatic send(input logic [7:0] b, input int gap);
      rx_data  = b;
      rx_valid = 1'b1;
      tick(1);
      rx_valid = 1'b0;
      tick(gap);
   endtask

   function automatic void ex(input logic [1:0] k, input logic [31:0] d, input logic l);
      ev_t e;
      e.kind = k;
      e.d    = d;
      e.last = l;
      exp_q.push_back(e);
   endfunction

   task automatic check_events(input string tag);
      tick(4);
      while (exp_q.size() > 0) begin
         ev_t e;
         e = exp_q.pop_front();
         if (obs_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s event: got none, want %0h", tag, e);
         end else begin
            chk($sformatf("%s event", tag), 64'(obs_q.pop_front()), 64'(e));
         end
      end
      while (obs_q.size() > 0) begin
         ev_t o;
         o = obs_q.pop_front();
         n_vec++;
         n_miss++;
         $display("FAIL %s extra event: got %0h, want none", tag, o);
      end
      chk($sformatf("%s err_code", tag), 64'(err_code), 64'(exp_code));
      chk($sformatf("%s busy", tag), 64'(busy), 64'd0);
   endtask

   task automatic run_vec(input int i, input int gap);
      logic [95:0] bb;
      bb = tbl[i].b;
      for (int k = 0; k < tbl[i].n; k++) begin
         send(bb[8*(tbl[i].n-1-k) +: 8], gap);
      end
      ex(EV_START, {16'h0, tbl[i].op, tbl[i].len}, 1'b0);
      if (tbl[i].nw >= 1) ex(EV_WORD, tbl[i].w0, tbl[i].nw == 1);
      if (tbl[i].nw == 2) ex(EV_WORD, tbl[i].w1, 1'b1);
      if (tbl[i].code == 0) begin
         ex(EV_DONE, 32'h0, 1'b0);
      end else begin
         ex(EV_ERR, 32'(tbl[i].code), 1'b0);
         exp_code = 2'(tbl[i].code);
      end
      check_events($sformatf("vec%0d", i));
   endtask

   // Random packet: checksum, payload words and abort points derived from packet rules
   task automatic rand_pkt(input int idx);
      logic [7:0] op, len, cs, g;
      logic [7:0] pl [16];
      logic [7:0] pk [20];
      logic [31:0] w;
      bit bad;
      int tmo_at, ntot, sent, ps, gap;
      op  = 8'($urandom);
      len = 8'($urandom_range(0, 12));
      cs  = op ^ len;
      for (int k = 0; k < int'(len); k++) begin
         pl[k] = 8'($urandom);
         cs    = cs ^ pl[k];
      end
      bad = ($urandom_range(0, 3) == 0);
      if (bad) cs = cs ^ 8'($urandom_range(1, 255));
      ntot   = 4 + int'(len);
      tmo_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, ntot - 2)) : -1;
      sent   = (tmo_at < 0) ? ntot : tmo_at + 1;
      pk[0] = 8'hA5;
      pk[1] = op;
      pk[2] = len;
      for (int k = 0; k < int'(len); k++) pk[3+k] = pl[k];
      pk[ntot-1] = cs;

      repeat ($urandom_range(0, 2)) begin
         g = 8'($urandom);
         if (g == 8'hA5) g = 8'h5A;
         send(g, int'($urandom_range(0, 3)));
      end
      for (int k = 0; k < sent; k++) begin
         if (k == tmo_at) gap = int'(T) + 2;
         else if ($urandom_range(0, 15) == 0) gap = int'(T) - 1;
         else gap = int'($urandom_range(0, 3));
         send(pk[k], gap);
      end

      if (sent >= 3) ex(EV_START, {16'h0, op, len}, 1'b0);
      ps = (sent < 3) ? 0 : sent - 3;
      if (ps > int'(len)) ps = int'(len);
      for (int i = 0; i < ps; i++) begin
         if ((i % 4 == 3) || (i == int'(len) - 1)) begin
            w = 32'h0;
            for (int j = i - (i % 4); j <= i; j++) w = w | (32'(pl[j]) << (8 * (j % 4)));
            ex(EV_WORD, w, i == int'(len) - 1);
         end
      end
      if (sent == ntot) begin
         if (bad) begin
            ex(EV_ERR, 32'd1, 1'b0);
            exp_code = 2'd1;
         end else begin
            ex(EV_DONE, 32'h0, 1'b0);
         end
      end else begin
         ex(EV_ERR, 32'd2, 1'b0);
         exp_code = 2'd2;
      end
      check_events($sformatf("rnd%0d", idx));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish, want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tbl[0] = '{96'hA5_10_03_11_22_33_13, 7, 8'h10, 8'h03, 1, 32'h00332211, 32'h0, 0};
      tbl[1] = '{96'hA5_01_08_01_02_03_04_05_06_07_08_01, 12, 8'h01, 8'h08, 2,
                 32'h04030201, 32'h08070605, 0};
      tbl[2] = '{96'hA5_10_03_11_22_33_20, 7, 8'h10, 8'h03, 1, 32'h00332211, 32'h0, 1};
      tbl[3] = '{96'hA5_7E_00_7E, 4, 8'h7E, 8'h00, 0, 32'h0, 32'h0, 0};
      tbl[4] = '{96'h00_FF_A5_A5_05_A5_01_02_03_04_01, 11, 8'hA5, 8'h05, 2,
                 32'h030201A5, 32'h00000004, 0};
      tbl[5] = '{96'hA5_33_02_AB_CD_57, 6, 8'h33, 8'h02, 1, 32'h0000CDAB, 32'h0, 0};
      tbl[6] = '{96'hA5_00_04_DE_AD_BE_EF_26, 8, 8'h00, 8'h04, 1, 32'hEFBEADDE, 32'h0, 0};

      #1 rst_n = 1'b0;
      #20;
      chk("reset outputs",
          64'({cmd_start, cmd_opcode, cmd_len, word_data, word_valid, word_last,
               pkt_done, pkt_err, err_code, busy}), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick(2);
      chk("idle busy", 64'(busy), 64'd0);

      // Directed table, bytes back to back
      for (int i = 0; i < NV; i++) run_vec(i, 0);

      // Timeout after LEN, checked cycle-exactly
      send(8'hA5, 0);
      send(8'h02, 0);
      send(8'h04, 0);
      tick(T - 1);
      chk("tmo not yet err", 64'(pkt_err), 64'd0);
      chk("tmo not yet busy", 64'(busy), 64'd1);
      tick(1);
      chk("tmo err pulse", 64'(pkt_err), 64'd1);
      chk("tmo err_code", 64'(err_code), 64'd2);
      chk("tmo busy", 64'(busy), 64'd0);
      ex(EV_START, {16'h0, 8'h02, 8'h04}, 1'b0);
      ex(EV_ERR, 32'd2, 1'b0);
      exp_code = 2'd2;
      check_events("tmo");
      send(8'h00, 0);
      send(8'hFF, 0);
      run_vec(0, 0);

      // Inter-byte gap exactly at the limit: byte wins over timeout
      run_vec(5, int'(T) - 1);
      // Gap one past the limit right after SYNC
      send(8'hA5, int'(T));
      ex(EV_ERR, 32'd2, 1'b0);
      check_events("tmo sync");

      // Overrun: second word load while first still held
      word_ready = 1'b0;
      send(8'hA5, 0);
      send(8'h01, 0);
      send(8'h08, 0);
      for (int k = 1; k <= 8; k++) send(8'(k), 0);
      chk("ovr err pulse", 64'(pkt_err), 64'd1);
      chk("ovr err_code", 64'(err_code), 64'd3);
      chk("ovr word_valid", 64'(word_valid), 64'd0);
      chk("ovr busy", 64'(busy), 64'd0);
      word_ready = 1'b1;
      ex(EV_START, {16'h0, 8'h01, 8'h08}, 1'b0);
      ex(EV_ERR, 32'd3, 1'b0);
      exp_code = 2'd3;
      check_events("ovr");

      // Ready arrives in the very cycle of the second load: no overrun
      word_ready = 1'b0;
      send(8'hA5, 0);
      send(8'h01, 0);
      send(8'h08, 0);
      for (int k = 1; k <= 7; k++) send(8'(k), 0);
      word_ready = 1'b1;
      send(8'h08, 0);
      send(8'h01, 0);
      ex(EV_START, {16'h0, 8'h01, 8'h08}, 1'b0);
      ex(EV_WORD, 32'h04030201, 1'b0);
      ex(EV_WORD, 32'h08070605, 1'b1);
      ex(EV_DONE, 32'h0, 1'b0);
      check_events("ovr edge");

      // Reset in the middle of the payload
      send(8'hA5, 0);
      send(8'h01, 0);
      send(8'h08, 0);
      send(8'h01, 0);
      send(8'h02, 0);
      rst_n = 1'b0;
      #1;
      chk("midrst outputs",
          64'({cmd_start, cmd_opcode, cmd_len, word_data, word_valid, word_last,
               pkt_done, pkt_err, err_code, busy}), 64'd0);
      tick(2);
      rst_n = 1'b1;
      tick(1);
      ex(EV_START, {16'h0, 8'h01, 8'h08}, 1'b0);
      exp_code = 2'd0;
      check_events("midrst");
      run_vec(3, 0);

      // Randomized packets against the packet-level model
      for (int r = 0; r < 40; r++) rand_pkt(r);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
